// File: rtl/if_fetch_queue.sv
// Instruction-fetch queue: issues in-order PC requests to instruction memory and
// buffers tagged {pc, instr} pairs for decode, with back-pressure and flush.
module if_fetch_queue #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               pc_valid,
  output logic               pc_ready,
  output logic               imem_req_valid,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               flush,
  output logic               id_valid,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [INSTR_W-1:0] id_instr,
  input  logic               id_ready,
  output logic               err
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;

  typedef logic [PtrW-1:0] ptr_t;

  localparam ptr_t DepthP = ptr_t'(DEPTH);

  ptr_t wr_q, wr_d;
  ptr_t fill_q, fill_d;
  ptr_t rd_q, rd_d;
  ptr_t drop_q, drop_d;
  logic err_q, err_d;

  logic [ADDR_W-1:0]  pc_q    [DEPTH];
  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [DEPTH-1:0]   full_q;

  logic [IdxW-1:0] wr_idx, fill_idx, rd_idx;
  ptr_t            used, outstanding;
  logic            credit_ok, accept, fill_en, pop;

  assign wr_idx      = wr_q[IdxW-1:0];
  assign fill_idx    = fill_q[IdxW-1:0];
  assign rd_idx      = rd_q[IdxW-1:0];
  assign used        = wr_q - rd_q;
  assign outstanding = wr_q - fill_q;

  assign credit_ok      = (used < DepthP) && (drop_q == '0) && reset && !flush;
  assign imem_req_valid = pc_valid && credit_ok;
  assign imem_req_addr  = pc_in;
  assign pc_ready       = credit_ok && imem_req_ready;
  assign accept         = imem_req_valid && imem_req_ready;

  assign id_valid = full_q[rd_idx] && (used != '0) && !flush && reset;
  assign id_pc    = pc_q[rd_idx];
  assign id_instr = instr_q[rd_idx];
  assign pop      = id_valid && id_ready;
  assign err      = err_q;

  always_comb begin
    wr_d    = wr_q;
    fill_d  = fill_q;
    rd_d    = rd_q;
    drop_d  = drop_q;
    err_d   = err_q;
    fill_en = 1'b0;
    if (flush) begin
      wr_d   = '0;
      fill_d = '0;
      rd_d   = '0;
      // A response landing in the flush cycle belongs to the abandoned stream.
      if (imem_rsp_valid && (drop_q == '0) && (outstanding == '0)) begin
        err_d  = 1'b1;
        drop_d = '0;
      end else begin
        drop_d = drop_q + outstanding - ptr_t'(imem_rsp_valid);
      end
    end else begin
      if (accept) begin
        wr_d = wr_q + ptr_t'(1);
      end
      if (imem_rsp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - ptr_t'(1);
        end else if (outstanding != '0) begin
          fill_d  = fill_q + ptr_t'(1);
          fill_en = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      if (pop) begin
        rd_d = rd_q + ptr_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q   <= '0;
      fill_q <= '0;
      rd_q   <= '0;
      drop_q <= '0;
      err_q  <= 1'b0;
      full_q <= '0;
    end else begin
      wr_q   <= wr_d;
      fill_q <= fill_d;
      rd_q   <= rd_d;
      drop_q <= drop_d;
      err_q  <= err_d;
      if (flush) begin
        full_q <= '0;
      end else begin
        // Accept and fill never target the same slot: a full ring blocks accepts.
        if (accept) begin
          full_q[wr_idx] <= 1'b0;
        end
        if (fill_en) begin
          full_q[fill_idx] <= 1'b1;
        end
      end
    end
  end

  // Payload storage carries no reset; validity lives in full_q.
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_q[wr_idx] <= pc_in;
    end
    if (fill_en) begin
      instr_q[fill_idx] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: cycle vectors with hand-computed outputs,
// plus a hand-written flush/drop sequence with a bounded wait.
module tb_if_fetch_queue;

  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned DEPTH   = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [ADDR_W-1:0]  pc_in;
  logic               pc_valid;
  logic               pc_ready;
  logic               imem_req_valid;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_req_ready;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               flush;
  logic               id_valid;
  logic [ADDR_W-1:0]  id_pc;
  logic [INSTR_W-1:0] id_instr;
  logic               id_ready;
  logic               err;

  if_fetch_queue #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_in         (pc_in),
    .pc_valid      (pc_valid),
    .pc_ready      (pc_ready),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .flush         (flush),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_instr      (id_instr),
    .id_ready      (id_ready),
    .err           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          pv;
    logic [63:0] pc;
    bit          rqr;
    bit          rv;
    logic [31:0] dat;
    bit          fl;
    bit          idr;
    bit          e_pcr;
    bit          e_rqv;
    bit          e_idv;
    logic [63:0] e_pc;
    logic [31:0] e_ins;
    bit          e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(input bit rst, input bit pv, input logic [63:0] pc,
                              input bit rqr, input bit rv, input logic [31:0] dat,
                              input bit fl, input bit idr, input bit e_pcr, input bit e_rqv,
                              input bit e_idv, input logic [63:0] e_pc,
                              input logic [31:0] e_ins, input bit e_err);
    vec_t v;
    v.rst = rst; v.pv = pv; v.pc = pc; v.rqr = rqr; v.rv = rv; v.dat = dat;
    v.fl = fl; v.idr = idr; v.e_pcr = e_pcr; v.e_rqv = e_rqv; v.e_idv = e_idv;
    v.e_pc = e_pc; v.e_ins = e_ins; v.e_err = e_err;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then settle for sampling.
  task automatic drive(input bit rst, input bit pv, input logic [63:0] pc, input bit rqr,
                       input bit rv, input logic [31:0] dat, input bit fl, input bit idr);
    @(negedge clk);
    reset          = rst;
    pc_valid       = pv;
    pc_in          = pc;
    imem_req_ready = rqr;
    imem_rsp_valid = rv;
    imem_rsp_data  = dat;
    flush          = fl;
    id_ready       = idr;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int  waited;
    bit  seen;

    // Reset held with pc_valid high: nothing may leave the block.
    for (int i = 0; i < 3; i++) add(0, 1, 'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Release; memory not ready first, then a 1-cycle memory streaming 4 PCs.
    add(1, 1, 'h0, 0, 0, 0,      0, 1, 0, 1, 0, 0,   0,      0);
    add(1, 1, 'h0, 1, 0, 0,      0, 1, 1, 1, 0, 0,   0,      0);
    add(1, 1, 'h4, 1, 1, 'h13,   0, 1, 1, 1, 0, 0,   0,      0);
    add(1, 1, 'h8, 1, 1, 'h113,  0, 1, 1, 1, 1, 'h0, 'h13,   0);
    add(1, 1, 'hC, 1, 1, 'h213,  0, 1, 1, 1, 1, 'h4, 'h113,  0);
    add(1, 0, 'h0, 1, 1, 'h313,  0, 1, 1, 0, 1, 'h8, 'h213,  0);
    add(1, 0, 'h0, 1, 0, 0,      0, 1, 1, 0, 1, 'hC, 'h313,  0);
    add(1, 0, 'h0, 1, 0, 0,      0, 1, 1, 0, 0, 0,   0,      0);
    // Decode stalled: four accepts fill the ring, a pop reopens it next cycle.
    add(1, 1, 'h0,  1, 0, 0,     0, 0, 1, 1, 0, 0,   0,      0);
    add(1, 1, 'h4,  1, 0, 0,     0, 0, 1, 1, 0, 0,   0,      0);
    add(1, 1, 'h8,  1, 0, 0,     0, 0, 1, 1, 0, 0,   0,      0);
    add(1, 1, 'hC,  1, 0, 0,     0, 0, 1, 1, 0, 0,   0,      0);
    add(1, 1, 'h10, 1, 1, 'hA0,  0, 0, 0, 0, 0, 0,   0,      0);
    add(1, 1, 'h10, 1, 1, 'hA4,  0, 1, 0, 0, 1, 'h0, 'hA0,   0);
    add(1, 1, 'h10, 1, 0, 0,     0, 0, 1, 1, 1, 'h4, 'hA4,   0);
    // Flush with 3 outstanding plus a same-cycle response: two more are dropped.
    add(1, 1, 'h100, 1, 1, 'hDEAD, 1, 1, 0, 0, 0, 0,     0,           0);
    add(1, 1, 'h100, 1, 1, 'hBAD1, 0, 1, 0, 0, 0, 0,     0,           0);
    add(1, 1, 'h100, 1, 1, 'hBAD2, 0, 1, 0, 0, 0, 0,     0,           0);
    add(1, 1, 'h100, 1, 0, 0,      0, 1, 1, 1, 0, 0,     0,           0);
    add(1, 0, 'h0,   1, 1, 'h1111_1111, 0, 1, 1, 0, 0, 0, 0,          0);
    add(1, 0, 'h0,   1, 0, 0,      0, 1, 1, 0, 1, 'h100, 'h1111_1111, 0);
    add(1, 0, 'h0,   1, 0, 0,      0, 1, 1, 0, 0, 0,     0,           0);
    // Stray response with nothing outstanding: sticky err, no entry.
    add(1, 0, 'h0, 1, 1, 'h77, 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 'h0, 1, 0, 0,    0, 0, 1, 0, 0, 0, 0, 1);
    add(1, 0, 'h0, 1, 0, 0,    0, 1, 1, 0, 0, 0, 0, 1);
    // Reset mid-operation with 2 filled entries and 1 outstanding.
    add(1, 1, 'h200, 1, 0, 0,    0, 0, 1, 1, 0, 0,      0,     1);
    add(1, 1, 'h204, 1, 1, 'h55, 0, 0, 1, 1, 0, 0,      0,     1);
    add(1, 1, 'h208, 1, 1, 'h66, 0, 0, 1, 1, 1, 'h200,  'h55,  1);
    add(0, 0, 'h0,   1, 0, 0,    0, 0, 0, 0, 0, 0,      0,     1);
    add(1, 0, 'h0,   1, 0, 0,    0, 0, 1, 0, 0, 0,      0,     0);
    add(1, 1, 'h0,   1, 0, 0,    0, 0, 1, 1, 0, 0,      0,     0);
    add(1, 0, 'h0,   1, 1, 'h13, 0, 1, 1, 0, 0, 0,      0,     0);
    add(1, 0, 'h0,   1, 0, 0,    0, 1, 1, 0, 1, 'h0,    'h13,  0);
    add(1, 0, 'h0,   1, 0, 0,    0, 1, 1, 0, 0, 0,      0,     0);

    drive(0, 0, 'h0, 1, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].pv, vecs[i].pc, vecs[i].rqr, vecs[i].rv, vecs[i].dat,
            vecs[i].fl, vecs[i].idr);
      chk($sformatf("v%0d pc_ready", i), 64'(pc_ready), 64'(vecs[i].e_pcr));
      chk($sformatf("v%0d imem_req_valid", i), 64'(imem_req_valid), 64'(vecs[i].e_rqv));
      chk($sformatf("v%0d id_valid", i), 64'(id_valid), 64'(vecs[i].e_idv));
      chk($sformatf("v%0d err", i), 64'(err), 64'(vecs[i].e_err));
      if (vecs[i].e_rqv) chk($sformatf("v%0d imem_req_addr", i), imem_req_addr, vecs[i].pc);
      if (vecs[i].e_idv) begin
        chk($sformatf("v%0d id_pc", i), id_pc, vecs[i].e_pc);
        chk($sformatf("v%0d id_instr", i), 64'(id_instr), 64'(vecs[i].e_ins));
      end
    end

    // Two requests in flight, flushed with no response: requests blocked until both drain.
    drive(1, 1, 'h300, 1, 0, 0, 0, 0);
    chk("seq accept 0x300", 64'(pc_ready), 64'd1);
    drive(1, 1, 'h304, 1, 0, 0, 0, 0);
    chk("seq accept 0x304", 64'(pc_ready), 64'd1);
    drive(1, 1, 'h400, 1, 0, 0, 1, 0);
    chk("seq flush pc_ready", 64'(pc_ready), 64'd0);
    chk("seq flush id_valid", 64'(id_valid), 64'd0);
    waited = 0;
    seen   = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      drive(1, 1, 'h400, 1, (k == 1 || k == 3), 'hBAD0, 0, 0);
      if (pc_ready) begin
        seen   = 1'b1;
        waited = k;
      end
    end
    chk("seq drain timeout", 64'(seen), 64'd1);
    chk("seq drain cycles", 64'(waited), 64'd4);
    chk("seq drop no err", 64'(err), 64'd0);
    drive(1, 0, 'h0, 1, 1, 'hCAFE_0013, 0, 1);
    chk("seq rsp no bypass", 64'(id_valid), 64'd0);
    drive(1, 0, 'h0, 1, 0, 0, 0, 1);
    chk("seq id_valid", 64'(id_valid), 64'd1);
    chk("seq id_pc", id_pc, 64'h400);
    chk("seq id_instr", 64'(id_instr), 64'hCAFE_0013);
    drive(1, 0, 'h0, 1, 0, 0, 0, 1);
    chk("seq drained", 64'(id_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
